// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha20 block finalize stage.
// Includes the RFC 7539 2.3.2 test block (input state, round output, keystream).
package chacha_pkg;

    localparam int unsigned WORD_BITS = 32;
    localparam int unsigned NUM_WORDS = 16;

    typedef logic [WORD_BITS-1:0] word_t;
    typedef word_t [3:0]          row_t;
    typedef word_t [3:0][3:0]     matrix_t;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        STREAM
    } state_t;

    // Word 0 sits in the least significant bits, so each row is listed col3..col0
    localparam matrix_t RFC_IN = {
        32'h00000000, 32'h4a000000, 32'h09000000, 32'h00000001,
        32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
        32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100,
        32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865
    };

    localparam matrix_t RFC_OUT = {
        32'h4e3c50a2, 32'h9e83d0cb, 32'hb04e16de, 32'hd19c12b4,
        32'h82e46ebd, 32'heabda8fc, 32'hf29489f3, 32'h335271c2,
        32'h3f5ec7b7, 32'h8fa018fc, 32'hfc62bb2f, 32'hc4f2d0c7,
        32'h5950bb2f, 32'ha67ae21e, 32'he238d763, 32'h837778ab
    };

    localparam matrix_t RFC_KS = {
        32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
        32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
        32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
        32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110
    };

endpackage

// File: rtl/chacha_row_adder.sv
// Four parallel modulo-2^WORD_W adders covering one matrix row; carries are dropped.
module chacha_row_adder #(
    parameter int unsigned WORD_W = 32
) (
    input  logic [3:0][WORD_W-1:0] a_i,
    input  logic [3:0][WORD_W-1:0] b_i,
    output logic [3:0][WORD_W-1:0] sum_o
);

    always_comb begin
        sum_o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            sum_o[c] = a_i[c] + b_i[c];
        end
    end

endmodule

// File: rtl/chacha_block_finalize.sv
// ChaCha20 block finalize: adds the round output to the input state row by row, then
// streams 16 keystream words. Optional CHACHA_FINALIZE_XOR_EN adds pt_data/ct_data.
module chacha_block_finalize
    import chacha_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              blockready,
    input  matrix_t           chachamatrixOUT,
    input  matrix_t           chachamatrixIN,
    input  logic              ks_ready,
    output logic              ks_valid,
    output logic [WORD_W-1:0] ks_data,
    output logic              ks_last,
    output logic              busy,
    output logic              overrun,
    output logic [CNT_W-1:0]  blocks_done
`ifdef CHACHA_FINALIZE_XOR_EN
    ,
    input  logic [WORD_W-1:0] pt_data,
    output logic [WORD_W-1:0] ct_data
`endif
);

    state_t              state_q;
    logic [1:0]          row_cnt_q;
    logic [3:0]          word_idx_q;
    logic [3:0]          word_idx_d;
    matrix_t             cap_out_q;
    matrix_t             cap_in_q;
    matrix_t             sum_q;
    row_t                row_sum;
    logic                ks_valid_q;
    logic                ks_last_q;
    logic [WORD_W-1:0]   ks_data_q;
    logic                overrun_q;
    logic [CNT_W-1:0]    blocks_done_q;
    logic                last_hs;
    logic                accept_blk;

    chacha_row_adder #(.WORD_W(WORD_W)) u_row_adder (
        .a_i   (cap_out_q[row_cnt_q]),
        .b_i   (cap_in_q[row_cnt_q]),
        .sum_o (row_sum)
    );

    // A new block is taken in IDLE or on the very edge that retires word 15
    always_comb begin
        word_idx_d = word_idx_q + 4'd1;
        last_hs    = (state_q == STREAM) && ks_valid_q && ks_ready
                     && (word_idx_q == 4'(NUM_WORDS - 1));
        accept_blk = blockready && ((state_q == IDLE) || last_hs);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            row_cnt_q     <= '0;
            word_idx_q    <= '0;
            cap_out_q     <= '0;
            cap_in_q      <= '0;
            sum_q         <= '0;
            ks_valid_q    <= 1'b0;
            ks_last_q     <= 1'b0;
            ks_data_q     <= '0;
            overrun_q     <= 1'b0;
            blocks_done_q <= '0;
        end else begin
            if (blockready && !accept_blk) begin
                overrun_q <= 1'b1;
            end
            if (accept_blk) begin
                cap_out_q <= chachamatrixOUT;
                cap_in_q  <= chachamatrixIN;
                row_cnt_q <= '0;
            end
            unique case (state_q)
                IDLE: begin
                    if (accept_blk) begin
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    sum_q[row_cnt_q] <= row_sum;
                    row_cnt_q        <= row_cnt_q + 2'd1;
                    if (row_cnt_q == 2'd3) begin
                        state_q    <= STREAM;
                        word_idx_q <= '0;
                        ks_valid_q <= 1'b1;
                        ks_data_q  <= sum_q[0][0];
                        ks_last_q  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (ks_valid_q && ks_ready) begin
                        if (last_hs) begin
                            blocks_done_q <= blocks_done_q + CNT_W'(1);
                            ks_valid_q    <= 1'b0;
                            ks_last_q     <= 1'b0;
                            word_idx_q    <= '0;
                            state_q       <= accept_blk ? ADD : IDLE;
                        end else begin
                            word_idx_q <= word_idx_d;
                            ks_data_q  <= sum_q[word_idx_d[3:2]][word_idx_d[1:0]];
                            ks_last_q  <= (word_idx_d == 4'(NUM_WORDS - 1));
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ks_valid    = ks_valid_q;
    assign ks_data     = ks_data_q;
    assign ks_last     = ks_last_q;
    assign busy        = (state_q != IDLE);
    assign overrun     = overrun_q;
    assign blocks_done = blocks_done_q;

`ifdef CHACHA_FINALIZE_XOR_EN
    assign ct_data = ks_data_q ^ pt_data;
`else
    // Raw keystream only
`endif

endmodule

// File: tb/tb_chacha_block_finalize.sv
// Self-checking bench for chacha_block_finalize: randomized blocks against a word-list
// addition model, plus the RFC 7539 block, backpressure, overrun, back-to-back and reset.
module tb_chacha_block_finalize;
    import chacha_pkg::*;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              blockready;
    matrix_t           m_out;
    matrix_t           m_in;
    logic              ks_ready;
    logic              ks_valid;
    logic [WORD_W-1:0] ks_data;
    logic              ks_last;
    logic              busy;
    logic              overrun;
    logic [CNT_W-1:0]  blocks_done;
`ifdef CHACHA_FINALIZE_XOR_EN
    logic [WORD_W-1:0] pt_data = '0;
    logic [WORD_W-1:0] ct_data;
    logic [31:0]       ct_q[$];
    logic [31:0]       pt_q[$];
`endif

    always #5 clk = ~clk;

    chacha_block_finalize #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .blockready      (blockready),
        .chachamatrixOUT (m_out),
        .chachamatrixIN  (m_in),
        .ks_ready        (ks_ready),
        .ks_valid        (ks_valid),
        .ks_data         (ks_data),
        .ks_last         (ks_last),
        .busy            (busy),
        .overrun         (overrun),
        .blocks_done     (blocks_done)
`ifdef CHACHA_FINALIZE_XOR_EN
        ,
        .pt_data         (pt_data),
        .ct_data         (ct_data)
`endif
    );

    int errors = 0;
    int checks = 0;
    int exp_blocks = 0;

    logic [31:0] cur_in[16];
    logic [31:0] cur_out[16];
    logic [31:0] nxt_in[16];
    logic [31:0] nxt_out[16];
    logic [31:0] exp_ks[16];
    logic [31:0] got_q[$];
    bit          last_q[$];
    int          wait_cyc, stream_cyc, stall_cyc, unstable;
    bit          timed_out;

    function automatic matrix_t pack(input logic [31:0] w[16]);
        matrix_t m;
        m = '0;
        for (int k = 0; k < 16; k++) m[k / 4][k % 4] = w[k];
        return m;
    endfunction

    task automatic set_model();
        for (int k = 0; k < 16; k++) exp_ks[k] = cur_in[k] + cur_out[k];
    endtask

    task automatic random_block();
        for (int k = 0; k < 16; k++) begin
            cur_in[k]  = $urandom;
            cur_out[k] = $urandom;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the capture edge
    task automatic pulse_block();
        m_in  = pack(cur_in);
        m_out = pack(cur_out);
        set_model();
        blockready = 1'b1;
        @(negedge clk);
        blockready = 1'b0;
        m_in  = '1;
        m_out = '1;
    endtask

    task automatic collect(input bit patterned, input bit b2b, input int stop_at);
        bit          r;
        bit          held_ok;
        logic [31:0] held_d;
        bit          held_l;
        got_q.delete();
        last_q.delete();
`ifdef CHACHA_FINALIZE_XOR_EN
        ct_q.delete();
        pt_q.delete();
`endif
        wait_cyc = 0; stream_cyc = 0; stall_cyc = 0; unstable = 0; timed_out = 0;
        held_ok = 0; held_d = '0; held_l = 0;
        ks_ready = 1'b0;
        while (!ks_valid && wait_cyc < 64) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (!ks_valid) begin
            timed_out = 1;
            return;
        end
        while (got_q.size() < stop_at && stream_cyc < 256) begin
            r = patterned ? ((stream_cyc % 4 == 0) || (stream_cyc % 4 == 3)) : 1'b1;
            ks_ready = r;
            if (held_ok && (!ks_valid || ks_data !== held_d || ks_last !== held_l)) unstable++;
            held_ok = 0;
            if (ks_valid) begin
                if (r) begin
                    got_q.push_back(ks_data);
                    last_q.push_back(ks_last);
`ifdef CHACHA_FINALIZE_XOR_EN
                    ct_q.push_back(ct_data);
                    pt_q.push_back(pt_data);
`endif
                    if (b2b && got_q.size() == 16) begin
                        m_in  = pack(nxt_in);
                        m_out = pack(nxt_out);
                        blockready = 1'b1;
                    end
                end else begin
                    stall_cyc++;
                    held_ok = 1;
                    held_d  = ks_data;
                    held_l  = ks_last;
                end
            end
            stream_cyc++;
            @(negedge clk);
            blockready = 1'b0;
        end
        ks_ready = 1'b0;
        if (got_q.size() < stop_at) timed_out = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; blockready = 1'b0; ks_ready = 1'b0; m_in = '0; m_out = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ks_valid, ks_last, busy, overrun} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: valid/last/busy/overrun=%b expected 0000",
                     {ks_valid, ks_last, busy, overrun});
        end
        checks++;
        if (ks_data !== '0 || blocks_done !== '0) begin
            errors++;
            $display("FAIL reset_data: ks_data=%h blocks_done=%0d expected 0/0", ks_data, blocks_done);
        end
        rst = 1'b0;
        exp_blocks = 0;
        @(negedge clk);
    endtask

    task automatic test_rfc_vector();
        matrix_t t_in, t_out, t_ks;
        logic [31:0] w;
        t_in = RFC_IN; t_out = RFC_OUT; t_ks = RFC_KS;
        for (int k = 0; k < 16; k++) begin
            cur_in[k]  = t_in[k / 4][k % 4];
            cur_out[k] = t_out[k / 4][k % 4];
        end
        pulse_block();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rfc_busy: busy=%b expected 1", busy); end
        collect(0, 0, 16);
        exp_blocks++;
        checks++;
        if (timed_out || got_q.size() != 16) begin
            errors++; $display("FAIL rfc_count: got %0d words expected 16", got_q.size());
        end
        checks++;
        if (wait_cyc != 4) begin errors++; $display("FAIL rfc_latency: %0d cycles expected 4", wait_cyc); end
        for (int k = 0; k < got_q.size(); k++) begin
            w = t_ks[k / 4][k % 4];
            checks++;
            if (got_q[k] !== w || got_q[k] !== exp_ks[k]) begin
                errors++; $display("FAIL rfc_word%0d: got %h expected %h", k, got_q[k], w);
            end
            checks++;
            if (last_q[k] !== (k == 15)) begin
                errors++; $display("FAIL rfc_last%0d: got %b expected %b", k, last_q[k], k == 15);
            end
        end
        checks++;
        if (blocks_done !== CNT_W'(exp_blocks) || busy !== 1'b0 || ks_valid !== 1'b0) begin
            errors++;
            $display("FAIL rfc_done: blocks_done=%0d busy=%b valid=%b expected %0d/0/0",
                     blocks_done, busy, ks_valid, exp_blocks);
        end
    endtask

    task automatic test_wrap_add();
        random_block();
        cur_in[0] = 32'hffffffff; cur_out[0] = 32'h00000002;
        cur_in[9] = 32'hffffffff; cur_out[9] = 32'hffffffff;
        pulse_block();
        collect(0, 0, 16);
        exp_blocks++;
        checks++;
        if (timed_out || got_q.size() != 16 || got_q[0] !== 32'h00000001) begin
            errors++; $display("FAIL wrap_word0: got %h expected 00000001", got_q.size() ? got_q[0] : 'x);
        end
        for (int k = 0; k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_ks[k]) begin
                errors++; $display("FAIL wrap_word%0d: got %h expected %h", k, got_q[k], exp_ks[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        int exp_stall, ones;
        exp_stall = 0; ones = 0;
        for (int c = 0; ones < 16; c++) begin
            if ((c % 4 == 0) || (c % 4 == 3)) ones++;
            else exp_stall++;
        end
        random_block();
        pulse_block();
        collect(1, 0, 16);
        exp_blocks++;
        checks++;
        if (timed_out || got_q.size() != 16) begin
            errors++; $display("FAIL bp_count: got %0d words expected 16", got_q.size());
        end
        for (int k = 0; k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_ks[k] || last_q[k] !== (k == 15)) begin
                errors++; $display("FAIL bp_word%0d: got %h/%b expected %h/%b",
                                   k, got_q[k], last_q[k], exp_ks[k], k == 15);
            end
        end
        checks++;
        if (unstable != 0) begin errors++; $display("FAIL bp_stable: %0d unstable stalls expected 0", unstable); end
        checks++;
        if (stall_cyc != exp_stall || stream_cyc != 16 + exp_stall) begin
            errors++; $display("FAIL bp_length: stalls=%0d cycles=%0d expected %0d/%0d",
                               stall_cyc, stream_cyc, exp_stall, 16 + exp_stall);
        end
        checks++;
        if (blocks_done !== CNT_W'(exp_blocks)) begin
            errors++; $display("FAIL bp_blocks: got %0d expected %0d", blocks_done, exp_blocks);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pt_a;
        pt_a = $urandom;
`ifdef CHACHA_FINALIZE_XOR_EN
        pt_data = pt_a;
`endif
        random_block();
        for (int k = 0; k < 16; k++) begin nxt_in[k] = 32'h1; nxt_out[k] = 32'h1; end
        pulse_block();
        collect(0, 1, 16);
        exp_blocks++;
        for (int k = 0; k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_ks[k]) begin
                errors++; $display("FAIL b2b_a_word%0d: got %h expected %h", k, got_q[k], exp_ks[k]);
            end
`ifdef CHACHA_FINALIZE_XOR_EN
            checks++;
            if (ct_q[k] !== (exp_ks[k] ^ pt_a)) begin
                errors++; $display("FAIL b2b_a_ct%0d: got %h expected %h", k, ct_q[k], exp_ks[k] ^ pt_a);
            end
`endif
        end
        checks++;
        if (busy !== 1'b1 || ks_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_capture: busy=%b valid=%b expected 1/0", busy, ks_valid);
        end
        cur_in = nxt_in; cur_out = nxt_out;
        set_model();
`ifdef CHACHA_FINALIZE_XOR_EN
        pt_data = 32'hffffffff;
`endif
        collect(0, 0, 16);
        exp_blocks++;
        checks++;
        if (timed_out || got_q.size() != 16 || wait_cyc != 4) begin
            errors++; $display("FAIL b2b_b_start: words=%0d latency=%0d expected 16/4", got_q.size(), wait_cyc);
        end
        for (int k = 0; k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== 32'h00000002 || got_q[k] !== exp_ks[k]) begin
                errors++; $display("FAIL b2b_b_word%0d: got %h expected 00000002", k, got_q[k]);
            end
`ifdef CHACHA_FINALIZE_XOR_EN
            checks++;
            if (ct_q[k] !== 32'hfffffffd) begin
                errors++; $display("FAIL b2b_b_ct%0d: got %h expected fffffffd", k, ct_q[k]);
            end
`endif
        end
        checks++;
        if (overrun !== 1'b0 || blocks_done !== CNT_W'(exp_blocks)) begin
            errors++; $display("FAIL b2b_status: overrun=%b blocks_done=%0d expected 0/%0d",
                               overrun, blocks_done, exp_blocks);
        end
    endtask

    task automatic test_overrun();
        random_block();
        pulse_block();
        m_in = '0; m_out = '0;
        for (int k = 0; k < 16; k++) begin
            m_in[k / 4][k % 4]  = $urandom;
            m_out[k / 4][k % 4] = $urandom;
        end
        blockready = 1'b1;
        @(negedge clk);
        blockready = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
        collect(0, 0, 16);
        exp_blocks++;
        checks++;
        if (timed_out || got_q.size() != 16) begin
            errors++; $display("FAIL ovr_count: got %0d words expected 16", got_q.size());
        end
        for (int k = 0; k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_ks[k]) begin
                errors++; $display("FAIL ovr_word%0d: got %h expected %h", k, got_q[k], exp_ks[k]);
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL ovr_sticky: overrun=%b busy=%b expected 1/0", overrun, busy);
        end
    endtask

    task automatic test_reset_midstream();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_blocks = 0;
        random_block();
        pulse_block();
        collect(0, 0, 7);
        checks++;
        if (timed_out || ks_valid !== 1'b1 || ks_data !== exp_ks[7]) begin
            errors++; $display("FAIL mid_word7: valid=%b data=%h expected 1/%h", ks_valid, ks_data, exp_ks[7]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ks_valid !== 1'b0 || busy !== 1'b0 || ks_last !== 1'b0 || blocks_done !== '0) begin
            errors++; $display("FAIL mid_abort: valid=%b busy=%b last=%b blocks=%0d expected 0/0/0/0",
                               ks_valid, busy, ks_last, blocks_done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        random_block();
        pulse_block();
        collect(0, 0, 16);
        exp_blocks++;
        checks++;
        if (timed_out || got_q.size() != 16) begin
            errors++; $display("FAIL mid_count: got %0d words expected 16", got_q.size());
        end
        for (int k = 0; k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_ks[k] || last_q[k] !== (k == 15)) begin
                errors++; $display("FAIL mid_word%0d: got %h/%b expected %h/%b",
                                   k, got_q[k], last_q[k], exp_ks[k], k == 15);
            end
        end
        checks++;
        if (blocks_done !== CNT_W'(exp_blocks)) begin
            errors++; $display("FAIL mid_blocks: got %0d expected %0d", blocks_done, exp_blocks);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rfc_vector();
        test_wrap_add();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
